// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite bus bundle between an AXI master and the SRAM bridge.
// Ports (signals):
//   AW: awaddr, awprot, awvalid / awready
//   W : wdata, wstrb, wvalid / wready
//   B : bresp, bvalid / bready
//   AR: araddr, arprot, arvalid / arready
//   R : rdata, rresp, rvalid / rready
// Modports: master (drives requests), slave (drives responses).
interface axi_lite_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_sram_bridge.sv
// AXI4-Lite slave to single-port synchronous SRAM bridge (1-cycle read latency).
// One transaction at a time; a pending write wins over a simultaneous read.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   axi           AXI4-Lite slave side (axi_lite_sram_if.slave)
//   mem_en/mem_we SRAM enable / write enable
//   mem_wstrb     SRAM byte write strobes
//   mem_addr      SRAM word address
//   mem_din       SRAM write data
//   mem_dout      SRAM read data (valid the cycle after mem_en)
// Build option: define AXI_SRAM_RANGE_CHECK_EN to answer SLVERR (without
// touching the SRAM) for addresses outside the SRAM inside the window.
// Without it the upper address bits alias and responses are always OKAY.
//
// state   | meaning
// IDLE    | accept AW/W independently, or AR when no write is pending
// WR_MEM  | one-cycle SRAM write
// WR_RESP | hold B response until bready
// RD_MEM  | SRAM read issued
// RD_CAP  | capture mem_dout into rdata
// RD_RESP | hold R response until rready
module axi_lite_sram_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int WINDOW_BITS    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_lite_sram_if.slave            axi,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_din,
  input  logic [DATA_WIDTH-1:0]     mem_dout
);

  typedef enum logic [2:0] {IDLE, WR_MEM, WR_RESP, RD_MEM, RD_CAP, RD_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t                  state, state_d;
  logic                    aw_held, w_held;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_hs, w_hs, ar_hs;
  logic                    wr_oor, rd_oor;

`ifdef AXI_SRAM_RANGE_CHECK_EN
  assign wr_oor = |awaddr_q[WINDOW_BITS-1:MEM_ADDR_WIDTH+2];
  assign rd_oor = |araddr_q[WINDOW_BITS-1:MEM_ADDR_WIDTH+2];
`else
  assign wr_oor = 1'b0;
  assign rd_oor = 1'b0;
`endif

  // prot and the address bits outside the word index carry no meaning here
  logic unused_bits;
  assign unused_bits = ^{axi.awprot, axi.arprot, awaddr_q, araddr_q};

  assign axi.rdata = rdata_q;

  always_comb begin
    state_d     = state;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.arready = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = RESP_OKAY;
    axi.rvalid  = 1'b0;
    axi.rresp   = RESP_OKAY;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_wstrb   = '0;
    mem_addr    = '0;
    mem_din     = '0;
    case (state)
      IDLE: begin
        if (!rst) begin
          axi.awready = !aw_held;
          axi.wready  = !w_held;
          // any write activity blocks reads, so writes win ties
          axi.arready = !aw_held && !w_held && !axi.awvalid && !axi.wvalid;
        end
        if ((aw_held || aw_hs) && (w_held || w_hs)) state_d = WR_MEM;
        else if (ar_hs)                            state_d = RD_MEM;
      end
      WR_MEM: begin
        mem_en    = !wr_oor;
        mem_we    = !wr_oor;
        mem_addr  = awaddr_q[MEM_ADDR_WIDTH+1:2];
        mem_wstrb = wstrb_q;
        mem_din   = wdata_q;
        state_d   = WR_RESP;
      end
      WR_RESP: begin
        axi.bvalid = 1'b1;
        axi.bresp  = wr_oor ? RESP_SLVERR : RESP_OKAY;
        if (axi.bready) state_d = IDLE;
      end
      RD_MEM: begin
        mem_en   = !rd_oor;
        mem_addr = araddr_q[MEM_ADDR_WIDTH+1:2];
        state_d  = RD_CAP;
      end
      RD_CAP: state_d = RD_RESP;
      RD_RESP: begin
        axi.rvalid = 1'b1;
        axi.rresp  = rd_oor ? RESP_SLVERR : RESP_OKAY;
        if (axi.rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;
  assign ar_hs = axi.arvalid && axi.arready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_d;
      if (aw_hs) begin
        awaddr_q <= axi.awaddr;
        aw_held  <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= axi.wdata;
        wstrb_q <= axi.wstrb;
        w_held  <= 1'b1;
      end
      if (ar_hs) araddr_q <= axi.araddr;
      if (state == RD_CAP) rdata_q <= rd_oor ? '0 : mem_dout;
      if (state == WR_RESP && axi.bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_bridge.sv
// Self-checking bench for axi_lite_sram_bridge: drives AXI-Lite at negedge,
// samples at negedge, models the SRAM and keeps expected B/R responses in
// queues that are popped when the DUT presents a response.
module tb_axi_lite_sram_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  logic        mem_en, mem_we;
  logic [3:0]  mem_wstrb;
  logic [7:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_clr;

  axi_lite_sram_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_WIDTH(8), .WINDOW_BITS(12)
  ) dut (
    .clk(clk), .rst(rst), .axi(bus),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  logic [31:0] sram [256];
  int we_cnt = 0;
  int en_cnt = 0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) sram[i] <= 32'h0;
    end else if (mem_en) begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) sram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
      mem_dout <= sram[mem_addr];
    end
    if (mem_en && mem_we) we_cnt <= we_cnt + 1;
    if (mem_en) en_cnt <= en_cnt + 1;
  end

  typedef struct {logic [31:0] d; logic [1:0] r;} rexp_t;
  logic [1:0]  b_q[$];
  rexp_t       r_q[$];
  logic [31:0] exp_mem [256];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic bit in_range(input logic [31:0] a);
`ifdef AXI_SRAM_RANGE_CHECK_EN
    return a[11:10] == 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_mem[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
      b_q.push_back(2'b00);
    end else begin
      b_q.push_back(2'b10);
    end
  endtask

  task automatic check_wr_mem(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    ok = in_range(a);
    chk("wr_mem_we", mem_we, ok);
    chk("wr_mem_en", mem_en, ok);
    if (ok) begin
      chk("wr_mem_addr", mem_addr, a[9:2]);
      chk("wr_mem_din", mem_din, d);
      chk("wr_mem_strb", mem_wstrb, s);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.awaddr = a; bus.awprot = 3'b010; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    #1;
    chk("aw_rdy", bus.awready, 1);
    chk("w_rdy", bus.wready, 1);
    model_write(a, d, s);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_wr_mem(a, d, s);
  endtask

  task automatic collect_b(input int exp_wait, input int hold);
    int waited = 0;
    logic [1:0] first, exp;
    while (!bus.bvalid && waited < 20) begin @(negedge clk); waited++; end
    chk("b_latency", waited, exp_wait);
    exp = (b_q.size() > 0) ? b_q.pop_front() : 2'bxx;
    if (!bus.bvalid) return;
    first = bus.bresp;
    for (int i = 0; i < hold; i++) begin
      chk("b_hold_valid", bus.bvalid, 1);
      chk("b_hold_resp", bus.bresp, first);
      chk("b_hold_awrdy", bus.awready, 0);
      @(negedge clk);
    end
    chk("bresp", bus.bresp, exp);
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    #1;
    chk("b_done", bus.bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] a);
    bit ok;
    rexp_t e;
    ok = in_range(a);
    bus.araddr = a; bus.arprot = 3'b001; bus.arvalid = 1'b1;
    #1;
    chk("ar_rdy", bus.arready, 1);
    e.d = ok ? exp_mem[a[9:2]] : 32'h0;
    e.r = ok ? 2'b00 : 2'b10;
    r_q.push_back(e);
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("rd_mem_en", mem_en, ok);
    chk("rd_mem_we", mem_we, 0);
    if (ok) chk("rd_mem_addr", mem_addr, a[9:2]);
  endtask

  task automatic collect_r(input int exp_wait, input int hold);
    int waited = 0;
    logic [31:0] first_d;
    logic [1:0]  first_r;
    rexp_t e;
    while (!bus.rvalid && waited < 20) begin @(negedge clk); waited++; end
    chk("r_latency", waited, exp_wait);
    if (r_q.size() > 0) e = r_q.pop_front();
    else begin e.d = 32'hx; e.r = 2'bxx; end
    if (!bus.rvalid) return;
    first_d = bus.rdata;
    first_r = bus.rresp;
    for (int i = 0; i < hold; i++) begin
      chk("r_hold_valid", bus.rvalid, 1);
      chk("r_hold_data", bus.rdata, first_d);
      chk("r_hold_resp", bus.rresp, first_r);
      chk("r_hold_awrdy", bus.awready, 0);
      @(negedge clk);
    end
    chk("rdata", bus.rdata, e.d);
    chk("rresp", bus.rresp, e.r);
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    #1;
    chk("r_done", bus.rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int we0, en0;
    rst = 1'b1; mem_clr = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_awrdy", bus.awready, 0);
    chk("rst_wrdy", bus.wready, 0);
    chk("rst_arrdy", bus.arready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_awrdy", bus.awready, 1);
    chk("post_rst_wrdy", bus.wready, 1);
    chk("post_rst_arrdy", bus.arready, 1);

    // simultaneous AW/W: write at N+1, B at N+2
    do_write(32'h010, 32'hDEADBEEF, 4'hF);
    collect_b(1, 0);

    // read back with rready low for 2 cycles
    do_read(32'h010);
    collect_r(2, 2);

    // AW first: awready drops while the address is held
    @(negedge clk);
    bus.awaddr = 32'h040; bus.awvalid = 1'b1;
    #1;
    chk("awfirst_rdy", bus.awready, 1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    #1;
    chk("aw_held_rdy", bus.awready, 0);
    chk("aw_held_wrdy", bus.wready, 1);
    chk("aw_held_arrdy", bus.arready, 0);
    bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    model_write(32'h040, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    bus.wvalid = 1'b0;
    check_wr_mem(32'h040, 32'hCAFEF00D, 4'hF);
    collect_b(1, 0);

    // W three cycles before AW, partial strobe, bready low for 5 cycles
    bus.wdata = 32'h12345678; bus.wstrb = 4'b0011; bus.wvalid = 1'b1;
    #1;
    chk("wfirst_rdy", bus.wready, 1);
    chk("wfirst_arrdy", bus.arready, 0);
    @(negedge clk);
    bus.wvalid = 1'b0;
    #1;
    chk("w_held_rdy", bus.wready, 0);
    chk("w_held_awrdy", bus.awready, 1);
    we0 = we_cnt;
    repeat (2) @(negedge clk);
    chk("w_held_no_we", we_cnt - we0, 0);
    bus.awaddr = 32'h020; bus.awvalid = 1'b1;
    #1;
    chk("wfirst_awrdy", bus.awready, 1);
    model_write(32'h020, 32'h12345678, 4'b0011);
    @(negedge clk);
    bus.awvalid = 1'b0;
    check_wr_mem(32'h020, 32'h12345678, 4'b0011);
    collect_b(1, 5);
    chk("we_pulses", we_cnt - we0, 1);

    // AW, W and AR together: write first, then read
    bus.awaddr = 32'h030; bus.awvalid = 1'b1;
    bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 32'h030; bus.arvalid = 1'b1;
    #1;
    chk("tie_arrdy", bus.arready, 0);
    chk("tie_awrdy", bus.awready, 1);
    model_write(32'h030, 32'hA5A5A5A5, 4'hF);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check_wr_mem(32'h030, 32'hA5A5A5A5, 4'hF);
    chk("tie_arrdy_wr", bus.arready, 0);
    collect_b(1, 0);
    do_read(32'h030);
    collect_r(2, 0);

    // upper window bits: SLVERR with range check, aliasing without
    we0 = we_cnt; en0 = en_cnt;
`ifdef AXI_SRAM_RANGE_CHECK_EN
    do_write(32'h400, 32'h55AA55AA, 4'hF);
    collect_b(1, 0);
    do_read(32'h7FC);
    collect_r(2, 0);
    chk("oor_no_we", we_cnt - we0, 0);
    chk("oor_no_en", en_cnt - en0, 0);
`else
    do_write(32'h400, 32'h0BADF00D, 4'hF);
    collect_b(1, 0);
    chk("alias_we", we_cnt - we0, 1);
    do_read(32'h000);
    collect_r(2, 0);
`endif

    // reset during RD_CAP abandons the read
    do_read(32'h020);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rdcap_rvalid", bus.rvalid, 0);
    chk("rst_rdcap_awrdy", bus.awready, 0);
    rst = 1'b0;
    r_q.delete();
    @(negedge clk);
    #1;
    chk("rst_rdcap_idle_aw", bus.awready, 1);
    chk("rst_rdcap_idle_w", bus.wready, 1);
    chk("rst_rdcap_rvalid2", bus.rvalid, 0);
    do_read(32'h020);
    collect_r(2, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_lite_sram_bridge.md
AXI_LITE_SRAM_BRIDGE -- requirements
Module: axi_lite_sram_bridge

Interface
REQ-001 The block SHALL have a parameter ADDR_WIDTH, default 32, which sets the AXI address width.
REQ-002 The block SHALL have a parameter DATA_WIDTH, default 32, which sets the AXI and SRAM data width.
REQ-003 The block SHALL have a parameter MEM_ADDR_WIDTH, default 8, which sets the SRAM word-address width (256 words).
REQ-004 The block SHALL have a parameter WINDOW_BITS, default 12, which sets the crossbar window size in address bits; WINDOW_BITS >= MEM_ADDR_WIDTH+2 SHALL hold.
REQ-005 The block SHALL use one clock and a synchronous active-high reset, on these ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
REQ-006 The AXI4-Lite write ports SHALL be:
- awaddr/awprot/awvalid  input  ADDR_WIDTH/3/1, and awready  output  1.
- wdata/wstrb/wvalid  input  DATA_WIDTH/DATA_WIDTH/8/1, and wready  output  1.
- bresp/bvalid  output  2/1, and bready  input  1.
REQ-007 The AXI4-Lite read ports SHALL be:
- araddr/arprot/arvalid  input  ADDR_WIDTH/3/1, and arready  output  1.
- rdata/rresp/rvalid  output  DATA_WIDTH/2/1, and rready  input  1.
REQ-008 The SRAM port (synchronous read, 1-cycle latency) SHALL be:
- mem_en  output  1.
- mem_we  output  1.
- mem_wstrb  output  DATA_WIDTH/8.
- mem_addr  output  MEM_ADDR_WIDTH.
- mem_din  output  DATA_WIDTH.
- mem_dout  input  DATA_WIDTH.

Function
REQ-009 The block SHALL be a single FSM with states IDLE, WR_MEM, WR_RESP, RD_MEM, RD_CAP and RD_RESP.
REQ-010 In IDLE, awready SHALL equal !aw_held and wready SHALL equal !w_held; AW and W SHALL be accepted independently and in either order, each latched with its own held flag.
REQ-011 In IDLE, arready SHALL be 1 only when !aw_held, !w_held, !awvalid and !wvalid, so a write wins over a simultaneous read.
REQ-012 When both AW and W are held or handshaking in the current cycle, the FSM SHALL go to WR_MEM; AW and W handshakes in the same cycle N SHALL give mem_we=1 in N+1 and bvalid=1 in N+2.
REQ-013 In WR_MEM, the block SHALL drive mem_en=1, mem_we=1, mem_addr=awaddr_q[MEM_ADDR_WIDTH+1:2], mem_wstrb=wstrb_q and mem_din=wdata_q for exactly one cycle, then go to WR_RESP.
REQ-014 In WR_RESP, bvalid SHALL stay 1 with bresp stable until bready=1; on that handshake the block SHALL clear both held flags and return to IDLE.
REQ-015 An AR handshake in cycle N SHALL give:
- RD_MEM in N+1: mem_en=1, mem_addr=araddr_q word index.
- RD_CAP in N+2: rdata <= mem_dout.
- RD_RESP from N+3: rvalid=1.
REQ-016 In RD_RESP, rdata, rresp and rvalid SHALL stay stable until rready=1, then the FSM SHALL return to IDLE.
REQ-017 The block SHALL ignore address bits [1:0]; awprot and arprot SHALL be accepted and ignored.
REQ-018 At most one transaction SHALL be outstanding; no AR SHALL be accepted during any write state and no AW/W during any read state.
REQ-019 Outside WR_MEM and RD_MEM, mem_en and mem_we SHALL be 0.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL go to IDLE, clear the held flags, and set awready, wready, arready, bvalid, rvalid, mem_en and mem_we to 0 and bresp, rresp and rdata to 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction with no response and no further SRAM write.
REQ-022 In the first cycle after reset release, awready and wready SHALL be 1.

Configuration
REQ-023 With AXI_SRAM_RANGE_CHECK_EN defined, any access with addr[WINDOW_BITS-1:MEM_ADDR_WIDTH+2] != 0 SHALL be treated as out of range:
- Write: no mem_we, bresp=2'b10 (SLVERR).
- Read: no mem_en, rdata=0, rresp=2'b10.
- State sequence and latency SHALL be unchanged.
REQ-024 Without AXI_SRAM_RANGE_CHECK_EN, the upper bits SHALL be ignored (address aliasing), and bresp and rresp SHALL always be 2'b00.

Verification
REQ-025 The bench SHALL cover: AW(0x010) and W(0xDEADBEEF, strb 4'hF) in cycle N -> mem_we=1 with mem_addr=4 in N+1, bvalid=1 with bresp=0 in N+2.
REQ-026 The bench SHALL cover: W handshake 3 cycles before AW, then bready held 0 for 5 cycles -> exactly one mem_we pulse, bvalid held for 5 cycles, awready=0 while aw_held.
REQ-027 The bench SHALL cover: AR(0x010) after the write above in cycle N, with rready=0 for 2 cycles -> rvalid rises in N+3 with rdata=0xDEADBEEF held stable, rresp=0.
REQ-028 The bench SHALL cover: awvalid, wvalid and arvalid all 1 in the same IDLE cycle -> arready=0, write completes first, then read accepted.
REQ-029 The bench SHALL cover: with the macro, AW(0x400)/W and AR(0x7FC) -> no mem_we and no mem_en, bresp=2'b10, rresp=2'b10 with rdata=0; without the macro, AW(0x400) -> write to word 0 with bresp=0.
REQ-030 The bench SHALL cover: rst=1 in RD_CAP -> next cycle rvalid=0 and FSM in IDLE; a subsequent read returns the correct data.
